fetch_decode_queue: RTL and testbench

- Instruction buffer between the fetch stage and the decode stage of the processor.
- Captures each fetched instruction together with its PC+4 value, and holds up to DEPTH entries in FIFO order.
- Presents entries to decode under a valid/ready handshake, so decode back-pressure no longer stalls the PC register directly.
- Discards all buffered entries on a taken branch, jump or jump-register (flush), and stops accepting new entries once the end-of-program instruction has been enqueued.

---
 rtl/fetch_decode_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_decode_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   Instruction buffer between fetch and decode. Each accepted fetch is stored
//   as {instruction, PC+4} in a DEPTH-entry circular FIFO. The head entry goes
//   to decode under a valid/ready handshake, so decode back-pressure no longer
//   stalls the PC register directly.
//   A flush (taken branch/jump/jump-register) discards every buffered entry.
//   Once the end-of-program instruction (low 12 bits == 12'h300) has been
//   enqueued, no further entries are accepted until a flush or reset.
//
// Parameters
//   DEPTH  number of entries, 2..16 (any value, need not be a power of two)
//   WIDTH  width of the instruction and PC+4 fields
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   in_valid         fetch presents an instruction
//   in_ready         queue can accept it (not full and end not seen)
//   in_instruction   fetched instruction word
//   in_pcPlus4       PC+4 of that instruction
//   flush            discard all contents; beats any enq/deq in the same cycle
//   out_valid        head entry is valid
//   out_ready        decode consumes the head entry
//   out_instruction  head instruction, 0 when empty (decode sees a NOP)
//   out_pcPlus4      head PC+4, 0 when empty
//   count            occupied entries, 0..DEPTH
//   endSeen          end-of-program instruction enqueued and not yet flushed
//
// Optional build macro QUEUE_STATS_EN adds saturating statistics outputs:
//   stallCycles   cycles with in_valid && !in_ready
//   bubbleCycles  cycles with out_ready && !out_valid
//   flushCount    flush assertions
//   These counters clear only on reset, never on flush.

module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_instruction,
  input  logic [WIDTH-1:0] in_pcPlus4,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instruction,
  output logic [WIDTH-1:0] out_pcPlus4,
  output logic [4:0]       count,
  output logic             endSeen
`ifdef QUEUE_STATS_EN
  ,
  output logic [31:0]      stallCycles,
  output logic [31:0]      bubbleCycles,
  output logic [15:0]      flushCount
`endif
);

  localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [4:0]     FULL_CNT = 5'(DEPTH);
  localparam logic [11:0]    END_CODE = 12'h300;

  logic [WIDTH-1:0] instrMem [DEPTH];
  logic [WIDTH-1:0] pcMem    [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             enq;
  logic             deq;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake is derived from registered state only; in_ready never looks at
  // out_ready, so a full queue does not pass through on a simultaneous deq.
  always_comb begin
    in_ready  = (count != FULL_CNT) && !endSeen;
    out_valid = (count != 5'd0);
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
  end

  always_comb begin
    out_instruction = '0;
    out_pcPlus4     = '0;
    if (out_valid) begin
      out_instruction = instrMem[rdPtr];
      out_pcPlus4     = pcMem[rdPtr];
    end
  end

  // ---- control state (pointers, occupancy, end marker) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= 5'd0;
      endSeen <= 1'b0;
    end else if (flush) begin
      // Stored words are left in place; they are simply unreachable now.
      rdPtr   <= '0;
      wrPtr   <= '0;
      count   <= 5'd0;
      endSeen <= 1'b0;
    end else begin
      if (enq) wrPtr <= nextPtr(wrPtr);
      if (deq) rdPtr <= nextPtr(rdPtr);
      case ({enq, deq})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      if (enq && (in_instruction[11:0] == END_CODE)) endSeen <= 1'b1;
    end
  end

  // ---- entry storage (data only, no reset) ----
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      instrMem[wrPtr] <= in_instruction;
      pcMem[wrPtr]    <= in_pcPlus4;
    end
  end

`ifdef QUEUE_STATS_EN
  function automatic logic [31:0] satInc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] satInc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  // ---- statistics counters ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCycles  <= 32'd0;
      bubbleCycles <= 32'd0;
      flushCount   <= 16'd0;
    end else begin
      if (in_valid && !in_ready)   stallCycles  <= satInc32(stallCycles);
      if (out_ready && !out_valid) bubbleCycles <= satInc32(bubbleCycles);
      if (flush)                   flushCount   <= satInc16(flushCount);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instruction;
  logic [WIDTH-1:0] in_pcPlus4;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instruction;
  logic [WIDTH-1:0] out_pcPlus4;
  logic [4:0]       count;
  logic             endSeen;
`ifdef QUEUE_STATS_EN
  logic [31:0]      stallCycles;
  logic [31:0]      bubbleCycles;
  logic [15:0]      flushCount;
`endif

  fetch_decode_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instruction(in_instruction),
    .in_pcPlus4(in_pcPlus4),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instruction(out_instruction),
    .out_pcPlus4(out_pcPlus4),
    .count(count),
    .endSeen(endSeen)
`ifdef QUEUE_STATS_EN
    ,
    .stallCycles(stallCycles),
    .bubbleCycles(bubbleCycles),
    .flushCount(flushCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  entry_t mq[$];
  logic   mEnd = 1'b0;
  logic   mReady;
  int     checks = 0;
  int     failures = 0;
`ifdef QUEUE_STATS_EN
  logic [31:0] mStall  = '0;
  logic [31:0] mBubble = '0;
  logic [15:0] mFlush  = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a plain queue stepped once per cycle on the falling edge,
  // when the inputs for the coming rising edge are already stable.
  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      mEnd = 1'b0;
`ifdef QUEUE_STATS_EN
      mStall = '0; mBubble = '0; mFlush = '0;
`endif
    end else begin
      mReady = (mq.size() != DEPTH) && !mEnd;
      chk("in_ready", 64'(in_ready), 64'(mReady));
      chk("count", 64'(count), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("endSeen", 64'(endSeen), 64'(mEnd));
      if (mq.size() != 0) begin
        chk("out_instruction", 64'(out_instruction), 64'(mq[0].instr));
        chk("out_pcPlus4", 64'(out_pcPlus4), 64'(mq[0].pc));
      end else begin
        chk("out_instruction_empty", 64'(out_instruction), 64'd0);
        chk("out_pcPlus4_empty", 64'(out_pcPlus4), 64'd0);
      end
`ifdef QUEUE_STATS_EN
      chk("stallCycles", 64'(stallCycles), 64'(mStall));
      chk("bubbleCycles", 64'(bubbleCycles), 64'(mBubble));
      chk("flushCount", 64'(flushCount), 64'(mFlush));
      if (in_valid && !mReady) mStall++;
      if (out_ready && mq.size() == 0) mBubble++;
      if (flush) mFlush++;
`endif
      if (flush) begin
        mq.delete();
        mEnd = 1'b0;
      end else begin
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (in_valid && mReady) begin
          mq.push_back('{instr: in_instruction, pc: in_pcPlus4});
          if (in_instruction[11:0] == 12'h300) mEnd = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid       = 1'b1;
    in_instruction = instr;
    in_pcPlus4     = pc;
    tick();
    in_valid       = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instruction = '0; in_pcPlus4 = '0;
    flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instruction", 64'(out_instruction), 64'd0);
    chk("rst_out_pcPlus4", 64'(out_pcPlus4), 64'd0);
    chk("rst_endSeen", 64'(endSeen), 64'd0);
    #12 reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Three entries held back by decode, then drained in order.
    push(32'h20010005, 32'h4);
    push(32'h20020007, 32'h8);
    push(32'h00221820, 32'hC);
    chk("fill3_count", 64'(count), 64'd3);
    chk("fill3_head", 64'(out_instruction), 64'h20010005);
    chk("fill3_pc", 64'(out_pcPlus4), 64'h4);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("drain_count", 64'(count), 64'd0);
    chk("drain_instr", 64'(out_instruction), 64'd0);
    out_ready = 1'b0;

    // Fill to DEPTH; a fifth offer must be ignored.
    for (int i = 0; i < DEPTH; i++) push(32'h11110000 + i, 32'h100 + 4 * i);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    push(32'h55555555, 32'h200);
    chk("full_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    repeat (2) tick();
    chk("half_count", 64'(count), 64'd2);

    // Simultaneous enq/deq at count 2 across pointer wrap.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_instruction = 32'h22220000 + i;
      in_pcPlus4     = 32'h300 + 4 * i;
      tick();
      chk("steady_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    chk("steady_drain", 64'(count), 64'd0);
    out_ready = 1'b0;

    // Flush with a concurrent input and deq.
    for (int i = 0; i < 3; i++) push(32'h33330000 + i, 32'h400 + 4 * i);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_instruction = 32'hDEAD0001; in_pcPlus4 = 32'h500;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (3) tick();
    out_ready = 1'b0;

    // End-of-program marker stops intake but still drains.
    push(32'h20010001, 32'h10);
    push(32'h20020002, 32'h14);
    push(32'h00000300, 32'h18);
    chk("end_endSeen", 64'(endSeen), 64'd1);
    chk("end_in_ready", 64'(in_ready), 64'd0);
    push(32'h20030003, 32'h1C);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("end_drained", 64'(count), 64'd0);
    chk("end_held", 64'(endSeen), 64'd1);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("end_cleared", 64'(endSeen), 64'd0);
    chk("end_ready_back", 64'(in_ready), 64'd1);

    // Asynchronous reset between edges.
    push(32'h44440000, 32'h600);
    push(32'h44440001, 32'h604);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_instruction", 64'(out_instruction), 64'd0);
    chk("arst_out_pcPlus4", 64'(out_pcPlus4), 64'd0);
    #3 reset = 1'b0;
    tick();

`ifdef QUEUE_STATS_EN
    for (int i = 0; i < DEPTH; i++) push(32'h66660000 + i, 32'h700 + 4 * i);
    in_valid = 1'b1; in_instruction = 32'h77777777;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("stats_stall3", 64'(stallCycles), 64'd3);
    flush = 1'b1;
    repeat (2) tick();
    flush = 1'b0;
    chk("stats_flush2", 64'(flushCount), 64'd2);
    chk("stats_stall_kept", 64'(stallCycles), 64'd3);
    chk("stats_bubble0", 64'(bubbleCycles), 64'd0);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("stats_bubble2", 64'(bubbleCycles), 64'd2);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
